// File: rtl/pipe_wire_pkg.sv
// Shared limits and sizing helper for the pipe_wire register pipeline.
// Optional occupancy output is enabled by defining PIPE_WIRE_OCC_EN.
package pipe_wire_pkg;

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned MAX_DEPTH = 16;

    // Bits needed to count 0..depth valid stages.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_wire_stage.sv
// One pipeline slot: valid/data register that loads from upstream whenever
// it is empty or the slot downstream can take its current beat.
module pipe_wire_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    input  logic             next_ready,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_comb begin
        ready = !valid || next_ready;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid <= 1'b0;
        end else if (ready) begin
            valid <= prev_valid;
        end
    end

    // Payload is deliberately not reset; only the valid bit qualifies it.
    always_ff @(posedge clk) begin
        if (ready) begin
            data <= prev_data;
        end
    end

endmodule

// File: rtl/pipe_wire.sv
// DEPTH-stage valid/ready register pipeline with fully combinational ready chain.
// Define PIPE_WIRE_OCC_EN to add the occupancy (valid-stage count) output.
module pipe_wire
    import pipe_wire_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_WIRE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH || DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_param
        $error("pipe_wire: WIDTH must be 1..64 and DEPTH 1..16");
    end

`ifdef PIPE_WIRE_OCC_EN
    localparam int unsigned OCC_W = occ_width(DEPTH);
    logic [DEPTH-1:0] stage_valid;
`endif

    // Each stage keeps its own ready net so the chain is a plain acyclic path.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             rdy;
        logic             nrdy;
        logic             pv;
        logic             v;
        logic [WIDTH-1:0] pd;
        logic [WIDTH-1:0] d;

        if (i == 0) begin : g_head
            assign pv = in_valid;
            assign pd = in_data;
        end else begin : g_body
            assign pv = g_stage[i-1].v;
            assign pd = g_stage[i-1].d;
        end

        if (i == DEPTH - 1) begin : g_tail
            assign nrdy = out_ready;
        end else begin : g_mid
            assign nrdy = g_stage[i+1].rdy;
        end

        pipe_wire_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .prev_valid(pv),
            .prev_data (pd),
            .next_ready(nrdy),
            .ready     (rdy),
            .valid     (v),
            .data      (d)
        );

`ifdef PIPE_WIRE_OCC_EN
        assign stage_valid[i] = v;
`endif
    end

    always_comb begin
        in_ready  = g_stage[0].rdy && !rst && !flush;
        out_valid = g_stage[DEPTH-1].v;
        out_data  = g_stage[DEPTH-1].d;
    end

`ifdef PIPE_WIRE_OCC_EN
    always_comb begin
        occupancy = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(stage_valid[k]);
        end
    end
`endif

endmodule

// File: doc/pipe_wire.md
PIPE_WIRE -- requirements
Module: pipe_wire

Interface
REQ-001 Parameter WIDTH, default 8, data bits per beat; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..16; DEPTH=0 SHALL raise an elaboration error.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous clear of all stages.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_data  input  WIDTH  upstream beat payload.
REQ-008 in_ready  output  1  pipe accepts a beat this cycle.
REQ-009 out_valid  output  1  beat present at pipe tail.
REQ-010 out_data  output  WIDTH  tail beat payload.
REQ-011 out_ready  input  1  downstream accepts tail beat.
REQ-012 occupancy  output  $clog2(DEPTH+1)  count of valid stages (present only with PIPE_WIRE_OCC_EN).

Function
REQ-013 Pipe SHALL be a chain of DEPTH stages, each holding valid bit v[i] and data d[i]; stage 0 at input, stage DEPTH-1 at output.
REQ-014 Transfer at input SHALL occur when in_valid && in_ready; at output when out_valid && out_ready.
REQ-015 Stage i SHALL be ready when !v[i] or stage i+1 ready (tail: !v[DEPTH-1] or out_ready); in_ready = stage 0 ready; ready chain combinational, no registered gaps.
REQ-016 Ready stage i SHALL load v[i-1]/d[i-1] (stage 0 loads in_valid/in_data); non-ready stage SHALL hold.
REQ-017 With out_ready held high, a beat accepted at edge N SHALL appear on out_valid/out_data after edge N+DEPTH-1 (latency DEPTH cycles from in_valid sampling to out_valid), throughput one beat per cycle.
REQ-018 out_valid = v[DEPTH-1], out_data = d[DEPTH-1]; both registered, no combinational in->out path.
REQ-019 Full: all v set and out_ready low -> in_ready SHALL be 0 and no data SHALL change.
REQ-020 Full with out_ready high: SHALL accept and emit in the same cycle; order preserved, no bubble inserted.
REQ-021 Bubbles SHALL collapse: an empty stage ahead of a stalled stage SHALL still fill.
REQ-022 out_data SHALL hold stable while out_valid && !out_ready.
REQ-023 flush SHALL clear all v[i] at the edge; beat presented same cycle SHALL be dropped; in_ready SHALL be 0 while flush is high.
REQ-024 Beats SHALL never be duplicated, dropped (except by flush/rst) or reordered.

Reset
REQ-025 rst SHALL clear all v[i] at the edge; out_valid=0, occupancy=0 after the edge; d[i] not reset.
REQ-026 in_ready SHALL be 0 while rst is high; rst SHALL override flush and any transfer.
REQ-027 rst mid-stream SHALL discard all in-flight beats; first beat after rst release follows REQ-017 latency.

Configuration
REQ-028 Macro PIPE_WIRE_OCC_EN defined: occupancy port present, equals popcount of v[], updated same edge as v[].
REQ-029 Macro undefined: occupancy port and counter logic absent; all other behaviour identical.

Structure
REQ-030 Package pipe_wire_pkg SHALL hold MAX_WIDTH=64, MAX_DEPTH=16 and the occupancy-width function.
REQ-031 One sub-module pipe_wire_stage (single valid/data register with ready logic), instantiated DEPTH times via generate.

Verification
REQ-032 WIDTH=8, DEPTH=4, out_ready=1, send 0x01..0x08 back-to-back -> 0x01 out_valid 4 cycles after first accept, then 0x02..0x08 on consecutive cycles.
REQ-033 Fill 4 beats with out_ready=0 -> in_ready=0 after 4th, occupancy=4, out_data=0x01 stable; raise out_ready -> drains in order, one per cycle.
REQ-034 Full pipe, out_ready=1, in_valid=1 with 0xAA -> same-cycle accept and emit, occupancy stays 4, 0xAA emerges after three more beats.
REQ-035 2 beats in flight, assert flush one cycle with in_valid=1 data 0x55 -> out_valid=0, occupancy=0 next cycle, 0x55 never emitted.
REQ-036 rst asserted mid-stream with flush also high -> all valid cleared, in_ready=0 during rst; after release, beat 0x33 emerges with 4-cycle latency.
REQ-037 Random in_valid/out_ready (10k beats, WIDTH=1 and WIDTH=64, DEPTH=1 and 16) -> scoreboard matches, no loss/duplication.
